// File: rtl/step_motor_pkg.sv
// Shared types and constants for the stepper-motor phase sequencer.
package step_motor_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Coil pattern {A,B,C,D} per phase index; odd entries drive two coils.
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  localparam logic [2:0] FULL_STRIDE = 3'd2;

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/step_tick_sync.sv
// Brings the slow step_clk into fpga_clk as data and emits a registered
// one-cycle tick per rising edge.
module step_tick_sync (
  input  logic fpga_clk,
  input  logic rst,
  input  logic step_clk,
  output logic tick
);

  logic s1_q, s2_q, s3_q, tick_q;

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= step_clk;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= s2_q & ~s3_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/step_motor_seq.sv
// Stepper-motor phase sequencer: accepts move commands, walks the phase
// table on each step tick, tracks position and drops coils after idle hold.
//
// state | meaning
// IDLE  | waiting for a command; idle ticks advance the hold timeout
// RUN   | stepping one phase per tick until remaining hits zero or abort
module step_motor_seq
  import step_motor_pkg::*;
#(
  parameter int STEP_W     = 16,
  parameter int POS_W      = 24,
  parameter int HOLD_TICKS = 200
) (
  input  logic              fpga_clk,
  input  logic              rst,
  input  logic              step_clk,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic [3:0]        coil,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  pos
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t              state_q;
  logic [2:0]          idx_q, idx_d, stride_d;
  logic [POS_W-1:0]    pos_q, pos_d, pos_delta;
  logic [3:0]          coil_q;
  logic                busy_q, done_q, dir_q, half_q;
  logic [STEP_W-1:0]   rem_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                tick, accept;

  step_tick_sync u_sync (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .step_clk (step_clk),
    .tick     (tick)
  );

  assign cmd_ready = ~rst & (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    stride_d  = half_q ? 3'd1 : FULL_STRIDE;
    pos_delta = {{(POS_W-3){1'b0}}, stride_d};
    idx_d     = dir_q ? idx_q + stride_d : idx_q - stride_d;
    pos_d     = dir_q ? pos_q + pos_delta : pos_q - pos_delta;
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      coil_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q  <= cmd_dir;
            half_q <= cmd_half;
            rem_q  <= cmd_steps;
            coil_q <= phase_of(idx_q);
            hold_q <= '0;
            if (cmd_steps != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end else if (tick && (HOLD_TICKS > 0) && (hold_q != HOLD_MAX)) begin
            hold_q <= hold_q + HOLD_ONE;
            if (hold_q == HOLD_MAX - HOLD_ONE) coil_q <= '0;
          end
        end
        RUN: begin
          // abort takes priority over a tick landing in the same cycle
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tick) begin
            idx_q  <= idx_d;
            pos_q  <= pos_d;
            coil_q <= phase_of(idx_d);
            rem_q  <= rem_q - STEP_ONE;
            if (rem_q == STEP_ONE) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coil = coil_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pos  = pos_q;

endmodule
